// File: rtl/seq_chk_ctrl.sv
// Serial pattern detector run controller: programmable pattern/length/target/timeout,
// non-overlapping detection on qualified bits, match counting and final status.
module seq_chk_ctrl #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int TO_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [3:0]       cfg_len,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic [TO_W-1:0]  cfg_timeout,
   input  logic             start,
   input  logic             abort,
   input  logic             din,
   input  logic             din_valid,
   output logic             busy,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_cnt,
   output logic             done,
   output logic             timeout_flag
);

   localparam int LW = $clog2(PAT_W + 1);

   typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [PAT_W-1:0] pat, pat_nxt, hist, hist_nxt, shifted, mask;
   logic [LW-1:0]    len, len_nxt, fill, fill_nxt, fill_inc, cfg_len_n;
   logic [CNT_W-1:0] target, target_nxt, cnt_nxt, cnt_inc;
   logic [TO_W-1:0]  tout, tout_nxt, timer, timer_nxt;
   logic             pulse_nxt, done_nxt, tflag_nxt;
   logic             hit, final_hit, expire;
   logic             do_load, do_run, do_idle;

   assign cfg_ready = (state == IDLE) || (state == DONE);
   assign busy      = (state == RUN);

   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < PAT_W; i++) begin
         mask[i] = (i < 32'(len));
      end
   end

   always_comb begin
      if (cfg_len == 4'd0 || 32'(cfg_len) > PAT_W) cfg_len_n = LW'(PAT_W);
      else                                         cfg_len_n = LW'(cfg_len);
   end

   // Match is evaluated on the history as it would look after capturing din.
   assign shifted   = {hist[PAT_W-2:0], din};
   assign fill_inc  = (fill == LW'(PAT_W)) ? fill : fill + LW'(1);
   assign hit       = din_valid && (fill_inc >= len) && (((shifted ^ pat) & mask) == '0);
   assign cnt_inc   = match_cnt + CNT_W'(1);
   assign final_hit = hit && (cnt_inc == target);
   assign expire    = (tout != '0) && (timer == tout - TO_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      pat_nxt    = pat;
      len_nxt    = len;
      target_nxt = target;
      tout_nxt   = tout;
      hist_nxt   = hist;
      fill_nxt   = fill;
      timer_nxt  = timer;
      cnt_nxt    = match_cnt;
      pulse_nxt  = 1'b0;
      done_nxt   = done;
      tflag_nxt  = timeout_flag;
      do_load    = 1'b0;
      do_run     = 1'b0;
      do_idle    = 1'b0;

      case (state)
         IDLE: begin
            if (cfg_valid) do_load = 1'b1;
         end
         ARMED: begin
            if (abort)      do_idle = 1'b1;
            else if (start) do_run  = 1'b1;
         end
         RUN: begin
            if (abort) begin
               do_idle = 1'b1;
            end else begin
               timer_nxt = timer + TO_W'(1);
               if (din_valid) begin
                  hist_nxt = shifted;
                  fill_nxt = fill_inc;
               end
               if (hit) begin
                  hist_nxt  = '0;
                  fill_nxt  = '0;
                  cnt_nxt   = cnt_inc;
                  pulse_nxt = 1'b1;
               end
               if (final_hit) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
                  tflag_nxt = 1'b0;
               end else if (expire) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
                  tflag_nxt = 1'b1;
               end
            end
         end
         DONE: begin
            if (abort)          do_idle = 1'b1;
            else if (cfg_valid) do_load = 1'b1;
            else if (start)     do_run  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase

      if (do_load) begin
         state_nxt  = ARMED;
         pat_nxt    = cfg_pattern;
         len_nxt    = cfg_len_n;
         target_nxt = (cfg_target == '0) ? CNT_W'(1) : cfg_target;
         tout_nxt   = cfg_timeout;
         done_nxt   = 1'b0;
         tflag_nxt  = 1'b0;
      end
      if (do_run) begin
         state_nxt = RUN;
         hist_nxt  = '0;
         fill_nxt  = '0;
         timer_nxt = '0;
         cnt_nxt   = '0;
         done_nxt  = 1'b0;
         tflag_nxt = 1'b0;
      end
      if (do_idle) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         pulse_nxt = 1'b0;
         done_nxt  = 1'b0;
         tflag_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat          <= '0;
         len          <= '0;
         target       <= '0;
         tout         <= '0;
         hist         <= '0;
         fill         <= '0;
         timer        <= '0;
         match_cnt    <= '0;
         match_pulse  <= 1'b0;
         done         <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         pat          <= pat_nxt;
         len          <= len_nxt;
         target       <= target_nxt;
         tout         <= tout_nxt;
         hist         <= hist_nxt;
         fill         <= fill_nxt;
         timer        <= timer_nxt;
         match_cnt    <= cnt_nxt;
         match_pulse  <= pulse_nxt;
         done         <= done_nxt;
         timeout_flag <= tflag_nxt;
      end
   end

endmodule

// File: tb/tb_seq_chk_ctrl.sv
// Bench for seq_chk_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_seq_chk_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [7:0]  cfg_pattern = '0;
   logic [3:0]  cfg_len = '0;
   logic [7:0]  cfg_target = '0;
   logic [15:0] cfg_timeout = '0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        din = 1'b0;
   logic        din_valid = 1'b0;
   logic        busy;
   logic        match_pulse;
   logic [7:0]  match_cnt;
   logic        done;
   logic        timeout_flag;

   int n_vec = 0;
   int n_err = 0;
   int pulses = 0;

   seq_chk_ctrl #(.PAT_W(8), .CNT_W(8), .TO_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
      .start(start), .abort(abort), .din(din), .din_valid(din_valid),
      .busy(busy), .match_pulse(match_pulse), .match_cnt(match_cnt),
      .done(done), .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: phase + a queue of valid bits since the last clear.
   localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_DONE = 3;
   int          m_phase = P_IDLE;
   bit          m_q[$];
   int          m_len, m_tgt, m_to, m_cyc, m_cnt;
   logic [7:0]  m_pat;
   bit          m_pulse, m_tflag, m_hit;

   function automatic bit tail_matches();
      int n = m_q.size();
      if (n < m_len) return 1'b0;
      for (int j = 0; j < m_len; j++)
         if (m_q[n - m_len + j] != m_pat[m_len - 1 - j]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_load();
      m_phase = P_ARMED;
      m_pat   = cfg_pattern;
      m_len   = (cfg_len == 0 || cfg_len > 8) ? 8 : int'(cfg_len);
      m_tgt   = (cfg_target == 0) ? 1 : int'(cfg_target);
      m_to    = int'(cfg_timeout);
      m_tflag = 1'b0;
   endtask

   task automatic m_begin_run();
      m_phase = P_RUN;
      m_q.delete();
      m_cyc   = 0;
      m_cnt   = 0;
      m_tflag = 1'b0;
   endtask

   task automatic m_go_idle();
      m_phase = P_IDLE;
      m_cnt   = 0;
      m_tflag = 1'b0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = P_IDLE;
         m_q.delete();
         m_len = 0; m_tgt = 0; m_to = 0; m_cyc = 0; m_cnt = 0;
         m_pat = '0; m_pulse = 1'b0; m_tflag = 1'b0;
      end else begin
         m_pulse = 1'b0;
         case (m_phase)
            P_IDLE:  if (cfg_valid) m_load();
            P_ARMED: if (abort) m_go_idle(); else if (start) m_begin_run();
            P_RUN: begin
               if (abort) m_go_idle();
               else begin
                  m_cyc++;
                  m_hit = 1'b0;
                  if (din_valid) begin
                     m_q.push_back(din);
                     if (m_q.size() > 8) void'(m_q.pop_front());
                     m_hit = tail_matches();
                  end
                  if (m_hit) begin
                     m_q.delete();
                     m_cnt++;
                     m_pulse = 1'b1;
                  end
                  if (m_hit && m_cnt == m_tgt) begin
                     m_phase = P_DONE; m_tflag = 1'b0;
                  end else if (m_to != 0 && m_cyc == m_to) begin
                     m_phase = P_DONE; m_tflag = 1'b1;
                  end
               end
            end
            default: begin
               if (abort)          m_go_idle();
               else if (cfg_valid) m_load();
               else if (start)     m_begin_run();
            end
         endcase
      end
   end

   always @(negedge clk) begin
      chk("cfg_ready",    32'(cfg_ready),    32'(m_phase == P_IDLE || m_phase == P_DONE));
      chk("busy",         32'(busy),         32'(m_phase == P_RUN));
      chk("done",         32'(done),         32'(m_phase == P_DONE));
      chk("match_pulse",  32'(match_pulse),  32'(m_pulse));
      chk("match_cnt",    32'(match_cnt),    32'(m_cnt));
      chk("timeout_flag", 32'(timeout_flag), 32'(m_tflag));
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_cfg(input logic [7:0] p, input logic [3:0] l,
                         input logic [7:0] t, input logic [15:0] to);
      cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_target = t; cfg_timeout = to;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Sends v[n-1] first, one valid bit per cycle.
   task automatic send(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         din = v[i]; din_valid = 1'b1;
         step();
         if (match_pulse) pulses++;
      end
      din_valid = 1'b0; din = 1'b0;
   endtask

   initial begin
      int nb;
      step(); step();
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_cnt",       32'(match_cnt), 32'd0);
      rst_n = 1'b1;
      step();

      // IDLE ignores start
      do_start();
      chk("idle_start_busy", 32'(busy), 32'd0);

      // single match
      do_cfg(8'b00100110, 4'd6, 8'd1, 16'd0);
      chk("armed_ready", 32'(cfg_ready), 32'd0);
      do_start();
      chk("run_busy", 32'(busy), 32'd1);
      pulses = 0;
      send(16'b100110, 6);
      chk("single_pulse", 32'(match_pulse), 32'd1);
      chk("single_cnt",   32'(match_cnt),   32'd1);
      chk("single_done",  32'(done),        32'd1);
      chk("single_tflag", 32'(timeout_flag), 32'd0);
      step();
      chk("single_pulse_width", 32'(match_pulse), 32'd0);
      chk("single_pulses", 32'(pulses), 32'd1);

      // re-run from DONE with same config
      do_start();
      chk("rerun_cnt_clear", 32'(match_cnt), 32'd0);
      send(16'b100110, 6);
      chk("rerun_cnt", 32'(match_cnt), 32'd1);

      // non-overlapping detection
      do_cfg(8'b00100110, 4'd6, 8'd2, 16'd0);
      do_start();
      pulses = 0;
      send(16'b1001100110, 10);
      chk("nonovl_pulses", 32'(pulses), 32'd1);
      chk("nonovl_done",   32'(done),   32'd0);
      send(16'b100110, 6);
      chk("nonovl_cnt2",   32'(match_cnt), 32'd2);
      chk("nonovl_done2",  32'(done),      32'd1);

      // start and cfg together in DONE: config wins; then timeout run
      cfg_valid = 1'b1; start = 1'b1;
      cfg_pattern = 8'b00001111; cfg_len = 4'd4; cfg_target = 8'd3; cfg_timeout = 16'd20;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      chk("cfg_wins_busy",  32'(busy),      32'd0);
      chk("cfg_wins_ready", 32'(cfg_ready), 32'd0);
      do_start();
      nb = 0;
      din = 1'b0; din_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (busy) nb++;
         step();
      end
      din_valid = 1'b0;
      chk("timeout_busy_cycles", 32'(nb), 32'd20);
      chk("timeout_flag", 32'(timeout_flag), 32'd1);
      chk("timeout_cnt",  32'(match_cnt),    32'd0);

      // final match on the timer's last cycle beats timeout
      do_cfg(8'b00001111, 4'd4, 8'd1, 16'd5);
      do_start();
      din_valid = 1'b0;
      step();
      send(16'b1111, 4);
      chk("final_vs_to_done",  32'(done),         32'd1);
      chk("final_vs_to_tflag", 32'(timeout_flag), 32'd0);
      chk("final_vs_to_cnt",   32'(match_cnt),    32'd1);

      // stalls on din_valid
      do_cfg(8'b00100110, 4'd6, 8'd1, 16'd0);
      do_start();
      for (int i = 5; i >= 0; i--) begin
         logic [5:0] p;
         p = 6'b100110;
         din = p[i]; din_valid = 1'b1; step();
         din = ~p[i]; din_valid = 1'b0; step();
      end
      chk("stall_cnt",  32'(match_cnt), 32'd1);
      chk("stall_done", 32'(done),      32'd1);

      // abort in the same cycle as a completing bit
      do_cfg(8'b00100110, 4'd6, 8'd2, 16'd0);
      do_start();
      send(16'b100110, 6);
      chk("abort_pre_cnt", 32'(match_cnt), 32'd1);
      send(16'b10011, 5);
      din = 1'b0; din_valid = 1'b1; abort = 1'b1;
      step();
      abort = 1'b0; din_valid = 1'b0;
      chk("abort_pulse", 32'(match_pulse), 32'd0);
      chk("abort_cnt",   32'(match_cnt),   32'd0);
      chk("abort_ready", 32'(cfg_ready),   32'd1);

      // abort from ARMED
      do_cfg(8'b00100110, 4'd6, 8'd1, 16'd0);
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_armed_ready", 32'(cfg_ready), 32'd1);

      // length 0 -> 8, target 0 -> 1
      do_cfg(8'b10110011, 4'd0, 8'd0, 16'd0);
      do_start();
      send(16'b1011001, 7);
      chk("len0_partial", 32'(match_cnt), 32'd0);
      send(16'b1, 1);
      chk("len0_cnt",  32'(match_cnt), 32'd1);
      chk("len0_done", 32'(done),      32'd1);

      // length 9 -> 8
      do_cfg(8'b01101110, 4'd9, 8'd1, 16'd0);
      do_start();
      send(16'b01101110, 8);
      chk("len9_cnt", 32'(match_cnt), 32'd1);

      // asynchronous reset mid-run
      do_cfg(8'b00100110, 4'd6, 8'd2, 16'd0);
      do_start();
      send(16'b100110, 6);
      send(16'b100, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ready", 32'(cfg_ready),    32'd1);
      chk("arst_busy",  32'(busy),         32'd0);
      chk("arst_cnt",   32'(match_cnt),    32'd0);
      chk("arst_done",  32'(done),         32'd0);
      chk("arst_tflag", 32'(timeout_flag), 32'd0);
      step();
      rst_n = 1'b1;
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
